// File: rtl/prf_wb_unit_if.sv
// Result-channel and PRF write-port bundle for prf_wb_unit.
// Handshake: a producer holds *_valid_in with stable fields until a posedge where *_ready_out is high; that edge transfers one result. Ready never depends on valid.
interface prf_wb_unit_if #(
  parameter int PREG_W = 7,
  parameter int DATA_W = 32
);
  logic              alu_valid_in, b_valid_in, mem_valid_in;
  logic              alu_ready_out, b_ready_out, mem_ready_out;
  logic              alu_has_rd_in, b_has_rd_in, mem_has_rd_in;
  logic [PREG_W-1:0] alu_pd_in, b_pd_in, mem_pd_in;
  logic [DATA_W-1:0] alu_data_in, b_data_in, mem_data_in;
  logic              write_alu_en, write_b_en, write_mem_en;
  logic [PREG_W-1:0] pd_alu_out, pd_b_out, pd_mem_out;
  logic [DATA_W-1:0] data_alu_out, data_b_out, data_mem_out;

  modport master (
    output alu_valid_in, b_valid_in, mem_valid_in,
    output alu_has_rd_in, b_has_rd_in, mem_has_rd_in,
    output alu_pd_in, b_pd_in, mem_pd_in,
    output alu_data_in, b_data_in, mem_data_in,
    input  alu_ready_out, b_ready_out, mem_ready_out,
    input  write_alu_en, write_b_en, write_mem_en,
    input  pd_alu_out, pd_b_out, pd_mem_out,
    input  data_alu_out, data_b_out, data_mem_out
  );

  modport slave (
    input  alu_valid_in, b_valid_in, mem_valid_in,
    input  alu_has_rd_in, b_has_rd_in, mem_has_rd_in,
    input  alu_pd_in, b_pd_in, mem_pd_in,
    input  alu_data_in, b_data_in, mem_data_in,
    output alu_ready_out, b_ready_out, mem_ready_out,
    output write_alu_en, write_b_en, write_mem_en,
    output pd_alu_out, pd_b_out, pd_mem_out,
    output data_alu_out, data_b_out, data_mem_out
  );
endinterface

// File: rtl/prf_wb_unit.sv
// PRF writeback front end: per-channel result FIFOs, three PRF write ports and the preg ready table.
// Optional macro PRF_WB_BYPASS_EN routes a result straight to an idle write port when its FIFO is empty.
module prf_wb_unit #(
  parameter int PREG_W     = 7,
  parameter int NUM_PREGS  = 128,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 stall_in,
  input  logic                 alloc_en,
  input  logic [PREG_W-1:0]    alloc_pd,
  output logic [NUM_PREGS-1:0] preg_ready_out,
  output logic                 dup_write_err,
  prf_wb_unit_if.slave         wb
);
  localparam int NCH   = 3;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [NCH-1:0]       w_valid, w_has_rd, w_ready, w_wen;
  logic [PREG_W-1:0]    w_pd_in   [NCH];
  logic [DATA_W-1:0]    w_data_in [NCH];
  logic [PREG_W-1:0]    w_pd_out  [NCH];
  logic [DATA_W-1:0]    w_data_out[NCH];
  logic [NUM_PREGS-1:0] r_ready, w_ready_nxt;
  logic                 r_dup, w_dup;

  // Channel order everywhere: 0 = ALU, 1 = branch, 2 = mem.
  assign w_valid      = {wb.mem_valid_in, wb.b_valid_in, wb.alu_valid_in};
  assign w_has_rd     = {wb.mem_has_rd_in, wb.b_has_rd_in, wb.alu_has_rd_in};
  assign w_pd_in[0]   = wb.alu_pd_in;
  assign w_pd_in[1]   = wb.b_pd_in;
  assign w_pd_in[2]   = wb.mem_pd_in;
  assign w_data_in[0] = wb.alu_data_in;
  assign w_data_in[1] = wb.b_data_in;
  assign w_data_in[2] = wb.mem_data_in;

  assign wb.alu_ready_out = w_ready[0];
  assign wb.b_ready_out   = w_ready[1];
  assign wb.mem_ready_out = w_ready[2];
  assign wb.write_alu_en  = w_wen[0];
  assign wb.write_b_en    = w_wen[1];
  assign wb.write_mem_en  = w_wen[2];
  assign wb.pd_alu_out    = w_pd_out[0];
  assign wb.pd_b_out      = w_pd_out[1];
  assign wb.pd_mem_out    = w_pd_out[2];
  assign wb.data_alu_out  = w_data_out[0];
  assign wb.data_b_out    = w_data_out[1];
  assign wb.data_mem_out  = w_data_out[2];

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic [PREG_W-1:0]     r_pd   [FIFO_DEPTH];
    logic [DATA_W-1:0]     r_data [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] r_rd;
    logic [PTR_W-1:0]      r_wptr, r_rptr;
    logic [CNT_W-1:0]      r_count;
    logic                  w_empty, w_push, w_pop, w_bypass, w_en;
    logic [PREG_W-1:0]     w_pd_o;
    logic [DATA_W-1:0]     w_data_o;

    assign w_empty    = (r_count == '0);
    assign w_ready[c] = (r_count < CNT_W'(FIFO_DEPTH));
`ifdef PRF_WB_BYPASS_EN
    assign w_bypass   = w_empty && !stall_in && !flush && w_valid[c];
`else
    assign w_bypass   = 1'b0;
`endif
    assign w_push = w_valid[c] && w_ready[c] && !flush && !w_bypass;
    assign w_pop  = !w_empty && !stall_in;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_count <= '0;
      end else if (flush) begin
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_count <= '0;
      end else begin
        if (w_push) r_wptr <= r_wptr + PTR_W'(1);
        if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
        if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
        else if (!w_push && w_pop) r_count <= r_count - CNT_W'(1);
      end
    end

    // Payload needs no reset: it is only observed while the count says non-empty.
    always_ff @(posedge clk) begin
      if (w_push) begin
        r_pd[r_wptr]   <= w_pd_in[c];
        r_data[r_wptr] <= w_data_in[c];
        r_rd[r_wptr]   <= w_has_rd[c];
      end
    end

    always_comb begin
      w_en     = 1'b0;
      w_pd_o   = '0;
      w_data_o = '0;
      if (w_bypass) begin
        w_en     = w_has_rd[c] && (w_pd_in[c] != '0);
        w_pd_o   = w_pd_in[c];
        w_data_o = w_data_in[c];
      end else if (!w_empty) begin
        w_en     = !stall_in && !flush && r_rd[r_rptr] && (r_pd[r_rptr] != '0);
        w_pd_o   = r_pd[r_rptr];
        w_data_o = r_data[r_rptr];
      end
    end

    assign w_wen[c]      = w_en;
    assign w_pd_out[c]   = w_pd_o;
    assign w_data_out[c] = w_data_o;
  end

  // Allocation clear is applied after the writeback sets so it wins on the same preg.
  always_comb begin
    w_ready_nxt = r_ready;
    for (int c = 0; c < NCH; c++) begin
      if (w_wen[c]) w_ready_nxt[w_pd_out[c]] = 1'b1;
    end
    if (alloc_en && (alloc_pd != '0)) w_ready_nxt[alloc_pd] = 1'b0;
    w_ready_nxt[0] = 1'b1;
  end

  assign w_dup = (w_wen[0] && w_wen[1] && (w_pd_out[0] == w_pd_out[1])) ||
                 (w_wen[0] && w_wen[2] && (w_pd_out[0] == w_pd_out[2])) ||
                 (w_wen[1] && w_wen[2] && (w_pd_out[1] == w_pd_out[2]));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ready <= '1;
      r_dup   <= 1'b0;
    end else begin
      r_ready <= w_ready_nxt;
      r_dup   <= w_dup;
    end
  end

  assign preg_ready_out = r_ready;
  assign dup_write_err  = r_dup;
endmodule

// File: tb/tb_prf_wb_unit.sv
// Self-checking bench for prf_wb_unit: directed scenarios plus randomized traffic against a queue-based model.
module tb_prf_wb_unit;
  localparam int PREG_W = 7, NUM_PREGS = 128, DATA_W = 32, DEPTH = 2, NCH = 3;
  localparam int EW = 1 + PREG_W + DATA_W;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 flush = 1'b0;
  logic                 stall_in = 1'b0;
  logic                 alloc_en = 1'b0;
  logic [PREG_W-1:0]    alloc_pd = '0;
  logic [NUM_PREGS-1:0] preg_ready_out;
  logic                 dup_write_err;

  logic              in_valid [NCH];
  logic              in_has_rd[NCH];
  logic [PREG_W-1:0] in_pd    [NCH];
  logic [DATA_W-1:0] in_data  [NCH];

  logic [NCH-1:0]    d_wen, d_rdy;
  logic [PREG_W-1:0] d_pd  [NCH];
  logic [DATA_W-1:0] d_data[NCH];

  // Reference model: one queue of {has_rd, pd, data} per channel plus a ready bit array.
  logic [EW-1:0]        exp_q[NCH][$];
  logic [NUM_PREGS-1:0] m_ready;
  logic                 m_dup;
  logic                 e_wen[NCH], e_rdy[NCH], e_byp[NCH];
  logic [PREG_W-1:0]    e_pd  [NCH];
  logic [DATA_W-1:0]    e_data[NCH];

  int n_checks = 0;
  int n_pass   = 0;

  prf_wb_unit_if #(.PREG_W(PREG_W), .DATA_W(DATA_W)) bus ();

  assign bus.alu_valid_in  = in_valid[0];
  assign bus.b_valid_in    = in_valid[1];
  assign bus.mem_valid_in  = in_valid[2];
  assign bus.alu_has_rd_in = in_has_rd[0];
  assign bus.b_has_rd_in   = in_has_rd[1];
  assign bus.mem_has_rd_in = in_has_rd[2];
  assign bus.alu_pd_in     = in_pd[0];
  assign bus.b_pd_in       = in_pd[1];
  assign bus.mem_pd_in     = in_pd[2];
  assign bus.alu_data_in   = in_data[0];
  assign bus.b_data_in     = in_data[1];
  assign bus.mem_data_in   = in_data[2];

  assign d_wen     = {bus.write_mem_en, bus.write_b_en, bus.write_alu_en};
  assign d_rdy     = {bus.mem_ready_out, bus.b_ready_out, bus.alu_ready_out};
  assign d_pd[0]   = bus.pd_alu_out;
  assign d_pd[1]   = bus.pd_b_out;
  assign d_pd[2]   = bus.pd_mem_out;
  assign d_data[0] = bus.data_alu_out;
  assign d_data[1] = bus.data_b_out;
  assign d_data[2] = bus.data_mem_out;

  prf_wb_unit #(
    .PREG_W(PREG_W), .NUM_PREGS(NUM_PREGS), .DATA_W(DATA_W), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .flush(flush), .stall_in(stall_in),
    .alloc_en(alloc_en), .alloc_pd(alloc_pd),
    .preg_ready_out(preg_ready_out), .dup_write_err(dup_write_err),
    .wb(bus)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // Model
  function automatic void model_reset();
    for (int c = 0; c < NCH; c++) exp_q[c].delete();
    m_ready = '1;
    m_dup   = 1'b0;
  endfunction

  function automatic void model_eval();
    logic [EW-1:0] h;
    for (int c = 0; c < NCH; c++) begin
      e_rdy[c]  = (exp_q[c].size() < DEPTH);
      e_byp[c]  = 1'b0;
      e_wen[c]  = 1'b0;
      e_pd[c]   = '0;
      e_data[c] = '0;
      if (exp_q[c].size() != 0) begin
        h = exp_q[c][0];
        e_pd[c]   = h[DATA_W +: PREG_W];
        e_data[c] = h[DATA_W-1:0];
        e_wen[c]  = !stall_in && !flush && h[EW-1] && (h[DATA_W +: PREG_W] != '0);
      end
`ifdef PRF_WB_BYPASS_EN
      else if (!stall_in && !flush && in_valid[c]) begin
        e_byp[c]  = 1'b1;
        e_pd[c]   = in_pd[c];
        e_data[c] = in_data[c];
        e_wen[c]  = in_has_rd[c] && (in_pd[c] != '0);
      end
`endif
    end
  endfunction

  function automatic void model_edge();
    logic [NUM_PREGS-1:0] nr;
    nr = m_ready;
    for (int c = 0; c < NCH; c++) if (e_wen[c]) nr[e_pd[c]] = 1'b1;
    if (alloc_en && alloc_pd != '0) nr[alloc_pd] = 1'b0;
    nr[0] = 1'b1;
    m_ready = nr;
    m_dup = 1'b0;
    for (int a = 0; a < NCH; a++)
      for (int b = a + 1; b < NCH; b++)
        if (e_wen[a] && e_wen[b] && e_pd[a] == e_pd[b]) m_dup = 1'b1;
    for (int c = 0; c < NCH; c++) begin
      if (flush) exp_q[c].delete();
      else begin
        if (exp_q[c].size() != 0 && !stall_in) void'(exp_q[c].pop_front());
        if (in_valid[c] && e_rdy[c] && !e_byp[c])
          exp_q[c].push_back({in_has_rd[c], in_pd[c], in_data[c]});
      end
    end
  endfunction

  // Driver tasks
  task automatic drive_ch(input int c, input logic v, input logic has,
                          input logic [PREG_W-1:0] pd, input logic [DATA_W-1:0] data);
    in_valid[c]  = v;
    in_has_rd[c] = has;
    in_pd[c]     = pd;
    in_data[c]   = data;
  endtask

  task automatic idle_inputs();
    for (int c = 0; c < NCH; c++) drive_ch(c, 1'b0, 1'b0, '0, '0);
    alloc_en = 1'b0;
    alloc_pd = '0;
  endtask

  task automatic sample();
    @(negedge clk);
    model_eval();
  endtask

  task automatic advance();
    @(posedge clk);
    model_eval();
    model_edge();
    #1;
  endtask

  // Scenarios
  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    sample();
    n_checks++;
    if (d_wen !== 3'b000) $display("FAIL reset_wen: got %b, exp 000", d_wen);
    else n_pass++;
    n_checks++;
    if (preg_ready_out !== {NUM_PREGS{1'b1}}) $display("FAIL reset_ready_table: got %h, exp all ones", preg_ready_out);
    else n_pass++;
    n_checks++;
    if (d_rdy !== 3'b111) $display("FAIL reset_ready_out: got %b, exp 111", d_rdy);
    else n_pass++;
    n_checks++;
    if (d_pd[0] !== '0 || d_pd[1] !== '0 || d_pd[2] !== '0 || dup_write_err !== 1'b0)
      $display("FAIL reset_outs: got pd %0d/%0d/%0d dup=%b, exp 0/0/0 dup=0", d_pd[0], d_pd[1], d_pd[2], dup_write_err);
    else n_pass++;
    advance();
  endtask

  task automatic test_alloc_mem();
    alloc_en = 1'b1;
    alloc_pd = 7'd5;
    advance();
    alloc_en = 1'b0;
    drive_ch(2, 1'b1, 1'b1, 7'd5, 32'hDEAD_BEEF);
    sample();
    n_checks++;
    if (preg_ready_out[5] !== 1'b0) $display("FAIL alloc_clear: got bit5=%b, exp 0", preg_ready_out[5]);
    else n_pass++;
    advance();
    drive_ch(2, 1'b0, 1'b0, '0, '0);
    sample();
    n_checks++;
    if (d_wen[2] !== 1'b1 || d_pd[2] !== 7'd5 || d_data[2] !== 32'hDEAD_BEEF)
      $display("FAIL mem_write: got en=%b pd=%0d data=%h, exp en=1 pd=5 data=deadbeef", d_wen[2], d_pd[2], d_data[2]);
    else n_pass++;
    n_checks++;
    if (preg_ready_out[5] !== 1'b0) $display("FAIL mem_latency: got bit5=%b before write edge, exp 0", preg_ready_out[5]);
    else n_pass++;
    advance();
    sample();
    n_checks++;
    if (preg_ready_out[5] !== 1'b1 || d_wen[2] !== 1'b0)
      $display("FAIL mem_ready_set: got bit5=%b en=%b, exp bit5=1 en=0", preg_ready_out[5], d_wen[2]);
    else n_pass++;
    advance();
  endtask

  task automatic test_stall();
    stall_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_ch(0, 1'b1, 1'b1, 7'(6 + i), 32'h1000_0006 + i);
      sample();
      n_checks++;
      if (d_rdy[0] !== (i < 2) || d_wen[0] !== 1'b0)
        $display("FAIL stall_accept%0d: got rdy=%b en=%b, exp rdy=%b en=0", i, d_rdy[0], d_wen[0], (i < 2));
      else n_pass++;
      advance();
    end
    stall_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sample();
      n_checks++;
      if (d_wen[0] !== 1'b1 || d_pd[0] !== 7'(6 + i) || d_data[0] !== 32'h1000_0006 + i)
        $display("FAIL stall_drain%0d: got en=%b pd=%0d data=%h, exp en=1 pd=%0d data=%h",
                 i, d_wen[0], d_pd[0], d_data[0], 6 + i, 32'h1000_0006 + i);
      else n_pass++;
      advance();
      if (i == 1) drive_ch(0, 1'b0, 1'b0, '0, '0);
    end
  endtask

  task automatic test_clear_wins();
    drive_ch(0, 1'b1, 1'b1, 7'd12, 32'hCAFE_BABE);
    advance();
    drive_ch(0, 1'b0, 1'b0, '0, '0);
    alloc_en = 1'b1;
    alloc_pd = 7'd12;
    sample();
    n_checks++;
    if (d_wen[0] !== 1'b1 || d_pd[0] !== 7'd12 || d_data[0] !== 32'hCAFE_BABE)
      $display("FAIL clear_wins_write: got en=%b pd=%0d data=%h, exp en=1 pd=12 data=cafebabe", d_wen[0], d_pd[0], d_data[0]);
    else n_pass++;
    advance();
    alloc_en = 1'b0;
    sample();
    n_checks++;
    if (preg_ready_out[12] !== 1'b0) $display("FAIL clear_wins_bit: got bit12=%b, exp 0", preg_ready_out[12]);
    else n_pass++;
    advance();
  endtask

  task automatic test_no_rd();
    drive_ch(1, 1'b1, 1'b0, 7'd20, 32'h0000_0055);
    drive_ch(0, 1'b1, 1'b1, 7'd0,  32'h0000_0077);
    advance();
    idle_inputs();
    sample();
    n_checks++;
    if (d_wen[0] !== 1'b0 || d_wen[1] !== 1'b0 || d_pd[1] !== 7'd20)
      $display("FAIL no_rd_head: got en_alu=%b en_b=%b pd_b=%0d, exp 0 0 20", d_wen[0], d_wen[1], d_pd[1]);
    else n_pass++;
    advance();
    sample();
    n_checks++;
    if (d_pd[1] !== '0 || d_data[0] !== '0 || d_rdy[1:0] !== 2'b11)
      $display("FAIL no_rd_popped: got pd_b=%0d data_alu=%h rdy=%b, exp 0 0 11", d_pd[1], d_data[0], d_rdy[1:0]);
    else n_pass++;
    n_checks++;
    if (preg_ready_out[0] !== 1'b1) $display("FAIL no_rd_bit0: got %b, exp 1", preg_ready_out[0]);
    else n_pass++;
    advance();
  endtask

  task automatic test_dup_flush();
    drive_ch(0, 1'b1, 1'b1, 7'd9, 32'hAAAA_0009);
    drive_ch(1, 1'b1, 1'b1, 7'd9, 32'hBBBB_0009);
    advance();
    idle_inputs();
    sample();
    n_checks++;
    if (d_wen[1:0] !== 2'b11 || d_pd[0] !== 7'd9 || d_pd[1] !== 7'd9 || dup_write_err !== 1'b0)
      $display("FAIL dup_writes: got en=%b pd=%0d/%0d dup=%b, exp en=11 pd=9/9 dup=0", d_wen[1:0], d_pd[0], d_pd[1], dup_write_err);
    else n_pass++;
    advance();
    sample();
    n_checks++;
    if (dup_write_err !== 1'b1) $display("FAIL dup_set: got %b, exp 1", dup_write_err);
    else n_pass++;
    advance();
    sample();
    n_checks++;
    if (dup_write_err !== 1'b0) $display("FAIL dup_one_cycle: got %b, exp 0", dup_write_err);
    else n_pass++;
    stall_in = 1'b1;
    drive_ch(0, 1'b1, 1'b1, 7'd30, 32'h3030_3030);
    advance();
    drive_ch(0, 1'b1, 1'b1, 7'd31, 32'h3131_3131);
    advance();
    drive_ch(0, 1'b1, 1'b1, 7'd32, 32'h3232_3232);
    flush = 1'b1;
    sample();
    n_checks++;
    if (d_wen[0] !== 1'b0 || d_rdy[0] !== 1'b0)
      $display("FAIL flush_cycle: got en=%b rdy=%b, exp en=0 rdy=0", d_wen[0], d_rdy[0]);
    else n_pass++;
    advance();
    flush = 1'b0;
    stall_in = 1'b0;
    idle_inputs();
    sample();
    n_checks++;
    if (d_wen[0] !== 1'b0 || d_pd[0] !== '0 || d_rdy[0] !== 1'b1)
      $display("FAIL flush_empty: got en=%b pd=%0d rdy=%b, exp en=0 pd=0 rdy=1", d_wen[0], d_pd[0], d_rdy[0]);
    else n_pass++;
    advance();
    sample();
    n_checks++;
    if (d_wen !== 3'b000) $display("FAIL flush_no_writes: got %b, exp 000", d_wen);
    else n_pass++;
    advance();
  endtask

  task automatic test_reset_mid();
    stall_in = 1'b1;
    drive_ch(0, 1'b1, 1'b1, 7'd40, 32'h4040_4040);
    advance();
    drive_ch(0, 1'b1, 1'b1, 7'd41, 32'h4141_4141);
    advance();
    idle_inputs();
    @(negedge clk);
    reset = 1'b1;
    #1;
    model_reset();
    n_checks++;
    if (d_rdy[0] !== 1'b1 || d_pd[0] !== '0 || preg_ready_out !== {NUM_PREGS{1'b1}})
      $display("FAIL reset_mid: got rdy=%b pd=%0d table=%h, exp rdy=1 pd=0 all ones", d_rdy[0], d_pd[0], preg_ready_out);
    else n_pass++;
    @(posedge clk);
    #1;
    reset = 1'b0;
    stall_in = 1'b0;
    sample();
    n_checks++;
    if (d_wen !== 3'b000) $display("FAIL reset_mid_no_write: got %b, exp 000", d_wen);
    else n_pass++;
    advance();
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int c = 0; c < NCH; c++)
        drive_ch(c, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
                 7'($urandom_range(0, 15)), $urandom);
      stall_in = ($urandom_range(0, 3) == 0);
      flush    = ($urandom_range(0, 31) == 0);
      alloc_en = ($urandom_range(0, 2) == 0);
      alloc_pd = 7'($urandom_range(0, 15));
      sample();
      for (int c = 0; c < NCH; c++) begin
        n_checks++;
        if (d_wen[c] !== e_wen[c] || d_pd[c] !== e_pd[c] || d_data[c] !== e_data[c] || d_rdy[c] !== e_rdy[c])
          $display("FAIL rand_ch%0d cyc %0d: got en=%b pd=%0d data=%h rdy=%b, exp en=%b pd=%0d data=%h rdy=%b",
                   c, cyc, d_wen[c], d_pd[c], d_data[c], d_rdy[c], e_wen[c], e_pd[c], e_data[c], e_rdy[c]);
        else n_pass++;
      end
      n_checks++;
      if (preg_ready_out !== m_ready || dup_write_err !== m_dup)
        $display("FAIL rand_table cyc %0d: got table=%h dup=%b, exp table=%h dup=%b",
                 cyc, preg_ready_out, dup_write_err, m_ready, m_dup);
      else n_pass++;
      advance();
    end
    idle_inputs();
    stall_in = 1'b0;
    flush    = 1'b0;
    advance();
  endtask

  initial begin
    test_reset();
    test_alloc_mem();
    test_stall();
    test_clear_wins();
    test_no_rd();
    test_dup_flush();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
